// File: rtl/nc_predictor.sv
// nC predictor for CAVLC coeff_token table select: left register + top line buffer, raster walk, frame wrap.
// Optional NC_CHROMA_DC_EN adds the chroma DC request input and nc_chroma_dc output (nC = -1).
module nc_predictor #(
    parameter int TC_W     = 5,
    parameter int BLK_COLS = 8,
    parameter int BLK_ROWS = 8,
    parameter int COL_W    = $clog2(BLK_COLS),
    parameter int ROW_W    = $clog2(BLK_ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sof,
    input  logic             i_blk_valid,
`ifdef NC_CHROMA_DC_EN
    input  logic             i_blk_chroma_dc,
    output logic             o_nc_chroma_dc,
`endif
    output logic             o_blk_ready,
    output logic [TC_W-1:0]  o_nc,
    output logic             o_nc_valid,
    output logic [COL_W-1:0] o_blk_col,
    output logic [ROW_W-1:0] o_blk_row,
    input  logic             i_tc_valid,
    input  logic [TC_W-1:0]  i_tc,
    output logic             o_frame_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CALC    = 2'd2,
        S_WAIT_TC = 2'd3
    } state_t;

    localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(16);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BLK_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_ROWS - 1);

    state_t           r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [TC_W-1:0]  r_left;
    logic [TC_W-1:0]  r_top [BLK_COLS];
    logic [TC_W-1:0]  r_top_rd;
    logic [TC_W-1:0]  r_nc;
    logic             r_nc_valid;
    logic [COL_W-1:0] r_blk_col;
    logic [ROW_W-1:0] r_blk_row;
    logic             r_blk_ready;
    logic             r_frame_done;

    logic             w_req_cdc;
    logic             w_is_cdc;
    logic             w_accept;
    logic             w_wb;
    logic [COL_W-1:0] w_rd_col;
    logic             w_na_avail;
    logic             w_nb_avail;
    logic [TC_W:0]    w_sum;
    logic [TC_W-1:0]  w_nc;
    logic [TC_W-1:0]  w_tc_sat;
    logic             w_last_col;
    logic             w_last_row;

`ifdef NC_CHROMA_DC_EN
    logic r_cdc;
    logic r_nc_cdc;
    assign w_req_cdc      = i_blk_chroma_dc;
    assign w_is_cdc       = r_cdc;
    assign o_nc_chroma_dc = r_nc_cdc;
`else
    assign w_req_cdc = 1'b0;
    assign w_is_cdc  = 1'b0;
`endif

    assign w_accept   = (r_state == S_IDLE) && i_blk_valid;
    assign w_wb       = (r_state == S_WAIT_TC) && i_tc_valid;
    // sof coinciding with a request means the block is (0,0), so read top[0]
    assign w_rd_col   = i_sof ? '0 : r_col;

    assign w_na_avail = (r_col != '0);
    assign w_nb_avail = (r_row != '0);
    assign w_sum      = {1'b0, r_left} + {1'b0, r_top_rd} + (TC_W+1)'(1);
    assign w_tc_sat   = (i_tc > TC_MAX) ? TC_MAX : i_tc;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);

    always_comb begin
        w_nc = '0;
        if (w_na_avail && w_nb_avail) begin
            w_nc = w_sum[TC_W:1];
        end else if (w_na_avail) begin
            w_nc = r_left;
        end else if (w_nb_avail) begin
            w_nc = r_top_rd;
        end
    end

    // Storage is deliberately unreset; availability masks whatever it holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept && !w_req_cdc) begin
            r_top_rd <= r_top[w_rd_col];
        end
        if (!i_rst && w_wb && !w_is_cdc) begin
            r_top[r_col] <= w_tc_sat;
            r_left       <= w_tc_sat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_nc         <= '0;
            r_nc_valid   <= 1'b0;
            r_blk_col    <= '0;
            r_blk_row    <= '0;
            r_blk_ready  <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef NC_CHROMA_DC_EN
            r_cdc        <= 1'b0;
            r_nc_cdc     <= 1'b0;
`endif
        end else begin
            r_nc_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_sof) begin
                        r_col <= '0;
                        r_row <= '0;
                    end
                    if (i_blk_valid) begin
                        r_state     <= S_READ;
                        r_blk_ready <= 1'b0;
`ifdef NC_CHROMA_DC_EN
                        r_cdc       <= i_blk_chroma_dc;
`endif
                    end
                end
                S_READ: begin
                    r_nc       <= w_is_cdc ? '0 : w_nc;
                    r_blk_col  <= r_col;
                    r_blk_row  <= r_row;
                    r_nc_valid <= 1'b1;
`ifdef NC_CHROMA_DC_EN
                    r_nc_cdc   <= r_cdc;
`endif
                    r_state    <= S_CALC;
                end
                S_CALC: begin
                    r_state <= S_WAIT_TC;
                end
                S_WAIT_TC: begin
                    if (i_tc_valid) begin
                        r_state     <= S_IDLE;
                        r_blk_ready <= 1'b1;
                        if (!w_is_cdc) begin
                            if (w_last_col) begin
                                r_col <= '0;
                                if (w_last_row) begin
                                    r_row        <= '0;
                                    r_frame_done <= 1'b1;
                                end else begin
                                    r_row <= r_row + ROW_W'(1);
                                end
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_blk_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_blk_ready  = r_blk_ready;
    assign o_nc         = r_nc;
    assign o_nc_valid   = r_nc_valid;
    assign o_blk_col    = r_blk_col;
    assign o_blk_row    = r_blk_row;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_nc_predictor.sv
// Directed, table-driven bench for nc_predictor (8x8 picture, TC_W=5).
module tb_nc_predictor;

    localparam int TC_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sof = 1'b0;
    logic            blk_valid = 1'b0;
    logic            tc_valid = 1'b0;
    logic [TC_W-1:0] tc = '0;
    logic            blk_ready;
    logic [TC_W-1:0] nc;
    logic            nc_valid;
    logic [2:0]      blk_col;
    logic [2:0]      blk_row;
    logic            frame_done;
`ifdef NC_CHROMA_DC_EN
    logic            blk_cdc = 1'b0;
    logic            nc_cdc;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TC_W-1:0] tc;
        logic [TC_W-1:0] nc;
        int              col;
        int              row;
    } vec_t;

    vec_t vecs[24];

    nc_predictor #(.TC_W(5), .BLK_COLS(8), .BLK_ROWS(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sof          (sof),
        .i_blk_valid    (blk_valid),
`ifdef NC_CHROMA_DC_EN
        .i_blk_chroma_dc(blk_cdc),
        .o_nc_chroma_dc (nc_cdc),
`endif
        .o_blk_ready    (blk_ready),
        .o_nc           (nc),
        .o_nc_valid     (nc_valid),
        .o_blk_col      (blk_col),
        .o_blk_row      (blk_row),
        .i_tc_valid     (tc_valid),
        .i_tc           (tc),
        .o_frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One block: request, collect nc at t+2, write back tc at t+3, sample at t+4.
    task automatic run_block(input logic [TC_W-1:0] tc_in, input logic with_sof,
                             output logic [TC_W-1:0] nc_o, output int col_o,
                             output int row_o, output logic fd_o);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!blk_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(blk_ready), 1);
        blk_valid = 1'b1;
        sof       = with_sof;
        @(negedge clk);
        blk_valid = 1'b0;
        sof       = 1'b0;
        lat = 1;
        while (!nc_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        nc_o  = nc;
        col_o = int'(blk_col);
        row_o = int'(blk_row);
        @(negedge clk);
        chk("nc_valid_pulse", int'(nc_valid), 0);
        tc_valid = 1'b1;
        tc       = tc_in;
        @(negedge clk);
        tc_valid = 1'b0;
        fd_o = frame_done;
        chk("ready_t4", int'(blk_ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TC_W-1:0] got_nc;
        int              got_col;
        int              got_row;
        logic            got_fd;
        int              fd_count;

        vecs[0]  = '{5'd7,  5'd0,  0, 0};
        vecs[1]  = '{5'd4,  5'd7,  1, 0};
        vecs[2]  = '{5'd16, 5'd4,  2, 0};
        vecs[3]  = '{5'd20, 5'd16, 3, 0};
        vecs[4]  = '{5'd0,  5'd16, 4, 0};
        vecs[5]  = '{5'd1,  5'd0,  5, 0};
        vecs[6]  = '{5'd2,  5'd1,  6, 0};
        vecs[7]  = '{5'd9,  5'd2,  7, 0};
        vecs[8]  = '{5'd3,  5'd7,  0, 1};
        vecs[9]  = '{5'd16, 5'd4,  1, 1};
        vecs[10] = '{5'd5,  5'd16, 2, 1};
        vecs[11] = '{5'd20, 5'd11, 3, 1};
        vecs[12] = '{5'd1,  5'd8,  4, 1};
        vecs[13] = '{5'd0,  5'd1,  5, 1};
        vecs[14] = '{5'd2,  5'd1,  6, 1};
        vecs[15] = '{5'd0,  5'd6,  7, 1};
        vecs[16] = '{5'd0,  5'd3,  0, 2};
        vecs[17] = '{5'd0,  5'd8,  1, 2};
        vecs[18] = '{5'd0,  5'd3,  2, 2};
        vecs[19] = '{5'd0,  5'd8,  3, 2};
        vecs[20] = '{5'd0,  5'd1,  4, 2};
        vecs[21] = '{5'd0,  5'd0,  5, 2};
        vecs[22] = '{5'd0,  5'd1,  6, 2};
        vecs[23] = '{5'd0,  5'd0,  7, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(blk_ready), 1);
        chk("rst_nc", int'(nc), 0);
        chk("rst_nc_valid", int'(nc_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_col", int'(blk_col), 0);
        chk("rst_row", int'(blk_row), 0);

        fd_count = 0;
        for (int i = 0; i < 24; i++) begin
            run_block(vecs[i].tc, 1'b0, got_nc, got_col, got_row, got_fd);
            chk($sformatf("tbl_nc[%0d]", i), int'(got_nc), int'(vecs[i].nc));
            chk($sformatf("tbl_col[%0d]", i), got_col, vecs[i].col);
            chk($sformatf("tbl_row[%0d]", i), got_row, vecs[i].row);
            chk($sformatf("tbl_fd[%0d]", i), int'(got_fd), 0);
            fd_count += int'(got_fd);
        end

        for (int i = 24; i < 64; i++) begin
            run_block(5'd0, 1'b0, got_nc, got_col, got_row, got_fd);
            chk($sformatf("fill_nc[%0d]", i), int'(got_nc), 0);
            chk($sformatf("fill_col[%0d]", i), got_col, i % 8);
            chk($sformatf("fill_row[%0d]", i), got_row, i / 8);
            chk($sformatf("fill_fd[%0d]", i), int'(got_fd), (i == 63) ? 1 : 0);
            fd_count += int'(got_fd);
        end
        chk("fd_count", fd_count, 1);
        @(negedge clk);
        chk("fd_one_cycle", int'(frame_done), 0);

        run_block(5'd9, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("wrap_col", got_col, 0);
        chk("wrap_row", got_row, 0);
        chk("wrap_nc", int'(got_nc), 0);
        run_block(5'd5, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("wrap1_nc", int'(got_nc), 9);
        chk("wrap1_col", got_col, 1);
        run_block(5'd12, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("wrap2_nc", int'(got_nc), 5);

        // sof alone in IDLE restarts at (0,0); stale left=12/top[0]=9 must be masked
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        run_block(5'd6, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("sof_col", got_col, 0);
        chk("sof_row", got_row, 0);
        chk("sof_nc", int'(got_nc), 0);

        // tc_valid in IDLE is ignored
        @(negedge clk);
        tc_valid = 1'b1;
        tc       = 5'd11;
        @(negedge clk);
        tc_valid = 1'b0;
        run_block(5'd3, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("idle_tc_col", got_col, 1);
        chk("idle_tc_nc", int'(got_nc), 6);

        run_block(5'd2, 1'b1, got_nc, got_col, got_row, got_fd);
        chk("sof_req_col", got_col, 0);
        chk("sof_req_row", got_row, 0);
        chk("sof_req_nc", int'(got_nc), 0);

        // rst while waiting for write-back
        @(negedge clk);
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", int'(nc_valid), 1);
        chk("pre_rst_nc", int'(nc), 2);
        chk("pre_rst_col", int'(blk_col), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(blk_ready), 1);
        chk("post_rst_col", int'(blk_col), 0);
        chk("post_rst_nc", int'(nc), 0);
        rst = 1'b0;
        run_block(5'd4, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("after_rst_col", got_col, 0);
        chk("after_rst_row", got_row, 0);
        chk("after_rst_nc", int'(got_nc), 0);

`ifdef NC_CHROMA_DC_EN
        blk_cdc = 1'b1;
        run_block(5'd13, 1'b0, got_nc, got_col, got_row, got_fd);
        blk_cdc = 1'b0;
        chk("cdc_nc", int'(got_nc), 0);
        chk("cdc_flag", int'(nc_cdc), 1);
        chk("cdc_col", got_col, 1);
        run_block(5'd0, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("after_cdc_col", got_col, 1);
        chk("after_cdc_nc", int'(got_nc), 4);
        chk("after_cdc_flag", int'(nc_cdc), 0);
`else
        run_block(5'd0, 1'b0, got_nc, got_col, got_row, got_fd);
        chk("last_col", got_col, 1);
        chk("last_nc", int'(got_nc), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
